ex_logic_shift_unit: RTL and testbench
======================================

Name: ex_logic_shift_unit

Overview:
Parametrised successor to the EX-stage logic unit. Executes bitwise, set-less-than and shift ops on DATA_W operands. Uses a valid/ready handshake on both sides. Shifts run iteratively, SHIFT_STEP bits per cycle, so a wide barrel shifter is not needed. Sits in EX beside the ALU. The ID stage supplies the decoded op and the selected shift amount; the EX result mux consumes the output.

Parameters:
DATA_W, 32, operand/result width (power of two, >=8)
SHIFT_STEP, 8, max bit positions shifted per cycle (power of two, 1..DATA_W)
SHAMT_W, $clog2(DATA_W), shift-amount width (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  pipeline flush; drop in-flight op
in_valid  in  1  request valid
in_ready  out  1  unit can accept this cycle
in_op  in  OP_W  decoded op (package enum)
in_op1  in  DATA_W  operand 1
in_op2  in  DATA_W  operand 2 (shift source)
in_shamt  in  SHAMT_W  shift amount (decoder selects shamt field or op1 low bits)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  DATA_W  result
out_illegal  out  1  op was not a supported encoding
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: state=IDLE, out_valid=0, out_result=0, out_illegal=0, busy=0; shift accumulator and remaining count =0.
- Ops:
  - OR/AND/XOR/NOR: bitwise.
  - SLT: signed compare, op1<op2 gives {0..,1}.
  - SLTU: unsigned compare.
  - SLL/SRL: logical shift of op2.
  - SRA: arithmetic shift of op2; fills with op2[DATA_W-1].
  - Any other encoding: result 0, out_illegal=1.
- FSM states:
  - IDLE: in_ready=1.
    - Accept (in_valid&&in_ready) of a non-shift op, or a shift with in_shamt==0: result registered, go to DONE.
    - Accept of a shift with in_shamt>0: acc<=op2, rem<=in_shamt, latch op, go to SHIFT.
  - SHIFT: each cycle step=min(rem,SHIFT_STEP); acc shifted by step; rem-=step. When rem reaches 0, go to DONE with out_result=acc.
  - DONE: out_valid=1, result held stable until out_ready.
    - On out_ready: go to IDLE.
    - If a new request is accepted in the same cycle, the next state follows the IDLE accept rules directly.
- in_ready = !flush && (state==IDLE || (state==DONE && out_ready)). Logic ops therefore sustain 1/cycle throughput.
- Latency, measured from the accept edge to out_valid: 1 cycle for non-shift ops and zero-amount shifts; 1+ceil(amt/SHIFT_STEP) cycles for shifts.
- Shift boundaries:
  - amt=DATA_W-1 is legal.
  - SRA of a negative value never leaks zeros.
  - Arithmetic on rem is SHAMT_W+1 wide; no wrap.
- flush (any state): next state IDLE, out_valid=0 next cycle, in-flight result discarded, no accept that cycle. Flush overrides out_ready handshake.
- rst_n low mid-SHIFT or in DONE: all outputs return to reset values on that edge.
- out_result and out_illegal change only on entry to DONE.

Optional Feature:
- Macro LOGIC_CLZ_EN.
- Defined: adds ops CLZ and CLO. Each counts leading zeros/ones of op1 (0..DATA_W, result zero-extended) with 1-cycle latency like the other logic ops. All-zero input to CLZ gives DATA_W.
- Undefined: CLZ/CLO encodings are treated as illegal (result 0, out_illegal=1); no count logic synthesised.

Decomposition:
- Shared package: op enum (OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_CLZ, OP_CLO), OP_W, FSM state typedef, is_shift() helper.
- One natural sub-module: lsu_shift_step. Combinational single-step shifter taking acc, step, direction and arith flag. Instantiated once in the SHIFT datapath.

Test Plan:
1. DATA_W=32. OR 0x0000_F0F0 | 0x0F0F_0000, out_ready=1 → out_valid one cycle after accept, result 0x0F0F_F0F0. Then back-to-back SLT 0xFFFF_FFFF vs 0x0000_0001 → result 1; SLTU on the same operands → 0.
2. SRA op2=0x8000_0000, amt=31, SHIFT_STEP=8 → out_valid 5 cycles after accept, result 0xFFFF_FFFF. SRL same inputs → 0x0000_0001.
3. SLL op2=0x0000_0001, amt=0 → 1-cycle latency, result 0x0000_0001; amt=12 → 3 cycles, 0x0000_1000.
4. Hold out_ready=0 for 4 cycles after a result → out_valid stays 1 and result stable, in_ready=0. Raise out_ready together with a new in_valid → same-cycle accept.
5. Assert flush during SHIFT (amt=20, second SHIFT cycle) → IDLE next cycle, out_valid never rises, following OR completes normally. Repeat with rst_n=0 mid-SHIFT → all outputs 0.
6. Illegal op encoding → result 0, out_illegal=1. With LOGIC_CLZ_EN, CLZ 0x0001_0000 → 15, CLZ 0 → 32, CLO 0xF000_0000 → 4. Without LOGIC_CLZ_EN, CLZ → out_illegal=1.

Source files
------------

// File: rtl/ex_logic_shift_unit_pkg.sv
// Shared types for the EX-stage logic/shift unit: op encodings, FSM states, helpers.
// CLZ/CLO encodings only execute when LOGIC_CLZ_EN is defined; otherwise they are illegal.
package ex_logic_shift_unit_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_OR   = 4'd0,
        OP_AND  = 4'd1,
        OP_XOR  = 4'd2,
        OP_NOR  = 4'd3,
        OP_SLT  = 4'd4,
        OP_SLTU = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_CLZ  = 4'd9,
        OP_CLO  = 4'd10
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/ex_logic_shift_unit_shift_step.sv
// Single-step shifter: moves acc by up to 2**(STEP_W-1) positions left, right or arithmetic right.
module lsu_shift_step #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STEP_W = 4
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [STEP_W-1:0] step,
    input  logic              shift_left,
    input  logic              arith,
    output logic [DATA_W-1:0] result_c
);

    always_comb begin
        result_c = acc;
        if (shift_left) begin
            result_c = acc << step;
        end else if (arith) begin
            result_c = $unsigned($signed(acc) >>> step);
        end else begin
            result_c = acc >> step;
        end
    end

endmodule

// File: rtl/ex_logic_shift_unit.sv
// EX-stage logic unit: bitwise, set-less-than and iterative shifts behind valid/ready handshakes.
// Optional leading-zero/one count ops are enabled by defining LOGIC_CLZ_EN.
module ex_logic_shift_unit
    import ex_logic_shift_unit_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SHIFT_STEP = 8,
    parameter int unsigned SHAMT_W    = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [DATA_W-1:0]  in_op1,
    input  logic [DATA_W-1:0]  in_op2,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic               out_illegal,
    output logic               busy
);

    localparam int unsigned STEP_W = $clog2(SHIFT_STEP) + 1;
    localparam int unsigned REM_W  = SHAMT_W + 1;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   res_d;
    logic                ill_d;
    logic                valid_d;

    logic [DATA_W-1:0]   logic_res;
    logic                logic_ill;
    logic [STEP_W-1:0]   step_c;
    logic [DATA_W-1:0]   step_res_c;
    logic [REM_W-1:0]    rem_next;
    logic                accept;

`ifdef LOGIC_CLZ_EN
    // Highest set bit wins because the scan runs from LSB upward.
    function automatic logic [DATA_W-1:0] lead_zeros(input logic [DATA_W-1:0] v);
        logic [REM_W-1:0] cnt;
        cnt = REM_W'(DATA_W);
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (v[i]) cnt = REM_W'(DATA_W - 1 - i);
        end
        return DATA_W'(cnt);
    endfunction
`endif

    assign in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Single-cycle result for everything except nonzero shifts.
    always_comb begin
        logic_res = '0;
        logic_ill = 1'b0;
        case (in_op)
            OP_OR:   logic_res = in_op1 | in_op2;
            OP_AND:  logic_res = in_op1 & in_op2;
            OP_XOR:  logic_res = in_op1 ^ in_op2;
            OP_NOR:  logic_res = ~(in_op1 | in_op2);
            OP_SLT:  logic_res = DATA_W'($signed(in_op1) < $signed(in_op2));
            OP_SLTU: logic_res = DATA_W'(in_op1 < in_op2);
            OP_SLL, OP_SRL, OP_SRA: logic_res = in_op2;
`ifdef LOGIC_CLZ_EN
            OP_CLZ:  logic_res = lead_zeros(in_op1);
            OP_CLO:  logic_res = lead_zeros(~in_op1);
`endif
            default: logic_ill = 1'b1;
        endcase
    end

    assign step_c   = (rem_q > REM_W'(SHIFT_STEP)) ? STEP_W'(SHIFT_STEP) : STEP_W'(rem_q);
    assign rem_next = rem_q - REM_W'(step_c);

    lsu_shift_step #(
        .DATA_W (DATA_W),
        .STEP_W (STEP_W)
    ) u_shift_step (
        .acc        (acc_q),
        .step       (step_c),
        .shift_left (op_q == OP_SLL),
        .arith      (op_q == OP_SRA),
        .result_c   (step_res_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        res_d   = out_result;
        ill_d   = out_illegal;
        valid_d = out_valid;

        case (state_q)
            ST_SHIFT: begin
                acc_d = step_res_c;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    state_d = ST_DONE;
                    res_d   = step_res_c;
                    ill_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Accept is only possible from IDLE or from DONE while the result drains.
        if (accept) begin
            if (is_shift(in_op) && (in_shamt != '0)) begin
                state_d = ST_SHIFT;
                acc_d   = in_op2;
                rem_d   = REM_W'(in_shamt);
                op_d    = in_op;
                valid_d = 1'b0;
            end else begin
                state_d = ST_DONE;
                res_d   = logic_res;
                ill_d   = logic_ill;
                valid_d = 1'b1;
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            rem_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            out_result  <= '0;
            out_illegal <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            out_result  <= res_d;
            out_illegal <= ill_d;
            out_valid   <= valid_d;
            busy        <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ex_logic_shift_unit.sv
// Directed self-checking bench for ex_logic_shift_unit (DATA_W=32, SHIFT_STEP=8).
module tb_ex_logic_shift_unit;
    import ex_logic_shift_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [31:0]       in_op1;
    logic [31:0]       in_op2;
    logic [4:0]        in_shamt;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic              out_illegal;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    ex_logic_shift_unit #(
        .DATA_W     (32),
        .SHIFT_STEP (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .in_shamt    (in_shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for out_valid, check latency/result/illegal flag.
    task automatic run_op(input string tag, input logic [OP_W-1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_ill);
        int lat;
        in_op    = op;
        in_op1   = a;
        in_op2   = b;
        in_shamt = sh;
        in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, out_result, exp_res);
        check({tag, "_ill"}, 32'(out_illegal), 32'(exp_ill));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_op1    = '0;
        in_op2    = '0;
        in_shamt  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Bitwise and compare ops, back to back
        run_op("or",   OP_OR,   32'h0000_F0F0, 32'h0F0F_0000, 5'd0, 1, 32'h0F0F_F0F0, 1'b0);
        run_op("slt",  OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1, 32'h0000_0001, 1'b0);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1, 32'h0000_0000, 1'b0);
        run_op("and",  OP_AND,  32'h1234_5678, 32'h0F0F_0F0F, 5'd0, 1, 32'h0204_0608, 1'b0);
        run_op("nor",  OP_NOR,  32'h0F0F_0F0F, 32'h00FF_00FF, 5'd0, 1, 32'hF000_F000, 1'b0);

        // Shifts
        run_op("sra31", OP_SRA, 32'h0, 32'h8000_0000, 5'd31, 5, 32'hFFFF_FFFF, 1'b0);
        run_op("srl31", OP_SRL, 32'h0, 32'h8000_0000, 5'd31, 5, 32'h0000_0001, 1'b0);
        run_op("sll0",  OP_SLL, 32'h0, 32'h0000_0001, 5'd0,  1, 32'h0000_0001, 1'b0);
        run_op("sll12", OP_SLL, 32'h0, 32'h0000_0001, 5'd12, 3, 32'h0000_1000, 1'b0);
        run_op("sll8",  OP_SLL, 32'h0, 32'h0000_0001, 5'd8,  2, 32'h0000_0100, 1'b0);
        run_op("sra4",  OP_SRA, 32'h0, 32'hF000_0000, 5'd4,  2, 32'hFF00_0000, 1'b0);

        // Backpressure: result held while out_ready is low
        tick();
        out_ready = 1'b0;
        run_op("xor", OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 1, 32'hF0F0_F0F0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", out_result, 32'hF0F0_F0F0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_op     = OP_AND;
        in_op1    = 32'hF0F0_F0F0;
        in_op2    = 32'hFF00_FF00;
        in_valid  = 1'b1;
        #1;
        check("drain_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd1);
        check("drain_result", out_result, 32'hF000_F000);

        // Flush during second SHIFT cycle
        in_op    = OP_SRL;
        in_op2   = 32'hFFFF_0000;
        in_shamt = 5'd20;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("flush_busy_pre", 32'(busy), 32'd1);
        tick();
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("flush_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        check("flush_result_kept", out_result, 32'hF000_F000);
        run_op("or_after_flush", OP_OR, 32'h0000_00A5, 32'h0000_5A00, 5'd0, 1, 32'h0000_5AA5, 1'b0);

        // Reset mid-SHIFT
        tick();
        in_op    = OP_SLL;
        in_op2   = 32'h0000_0003;
        in_shamt = 5'd20;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result", out_result, 32'd0);
        check("rst_mid_illegal", 32'(out_illegal), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Illegal encodings and optional count ops
        run_op("illegal", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1, 32'h0, 1'b1);
        run_op("or_legal", OP_OR, 32'h1, 32'h2, 5'd0, 1, 32'h3, 1'b0);
`ifdef LOGIC_CLZ_EN
        run_op("clz16", OP_CLZ, 32'h0001_0000, 32'h0, 5'd0, 1, 32'd15, 1'b0);
        run_op("clz0",  OP_CLZ, 32'h0000_0000, 32'h0, 5'd0, 1, 32'd32, 1'b0);
        run_op("clo4",  OP_CLO, 32'hF000_0000, 32'h0, 5'd0, 1, 32'd4,  1'b0);
`else
        run_op("clz_ill", OP_CLZ, 32'h0001_0000, 32'h0, 5'd0, 1, 32'h0, 1'b1);
        run_op("clo_ill", OP_CLO, 32'hF000_0000, 32'h0, 5'd0, 1, 32'h0, 1'b1);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
